// File: rtl/missle_pkg.sv
// Shared constants for the missile pool: coordinate width, slot index width
// and the default timing/geometry values used by the pool controller.
package missle_pkg;
   localparam int XY_W         = 11;
   localparam int SLOT_IDX_W   = 3;
   localparam int N_SLOTS_DEF  = 4;
   localparam int STEP_DIV_DEF = 90000;
   localparam int COOLDOWN_DEF = 2000000;
   localparam int Y_START_DEF  = 704;
   localparam int Y_MIN_DEF    = 80;
endpackage

// File: rtl/missle_pool_ctl_if.sv
// Bus between ship/input logic, collision logic and the missile draw stage.
interface missle_pool_ctl_if
   import missle_pkg::*;
#(
   parameter int N_SLOTS = N_SLOTS_DEF
);
   logic [XY_W-1:0]         xpos_in;
   logic                    missle_button;
   logic                    ship_dead;
   logic [N_SLOTS-1:0]      hit_in;
   logic [XY_W*N_SLOTS-1:0] xpos_out;
   logic [XY_W*N_SLOTS-1:0] ypos_out;
   logic [N_SLOTS-1:0]      on_out;
   logic                    launch_out;
   logic [SLOT_IDX_W-1:0]   launch_slot_out;

   modport master (
      output xpos_in, missle_button, ship_dead, hit_in,
      input  xpos_out, ypos_out, on_out, launch_out, launch_slot_out
   );

   modport slave (
      input  xpos_in, missle_button, ship_dead, hit_in,
      output xpos_out, ypos_out, on_out, launch_out, launch_slot_out
   );
endinterface

// File: rtl/missle_slot.sv
// One missile slot: position and active flag with clear, hit, load and step
// controls applied in that priority order.
module missle_slot
   import missle_pkg::*;
#(
   parameter int Y_START = Y_START_DEF,
   parameter int Y_MIN   = Y_MIN_DEF
) (
   input  logic            pclk,
   input  logic            rst,
   input  logic            clear,
   input  logic            hit,
   input  logic            load,
   input  logic            tick,
   input  logic [XY_W-1:0] x_load,
   output logic [XY_W-1:0] xpos,
   output logic [XY_W-1:0] ypos,
   output logic            on
);
   localparam logic [XY_W-1:0] Y_START_C = XY_W'(Y_START);
   localparam logic [XY_W-1:0] Y_MIN_C   = XY_W'(Y_MIN);

   // x is held on clear/hit/retire so the draw stage keeps a stable column
   always_ff @(posedge pclk) begin
      if (rst) begin
         on   <= 1'b0;
         xpos <= '0;
         ypos <= Y_START_C;
      end else if (clear || (hit && on)) begin
         on   <= 1'b0;
         ypos <= Y_START_C;
      end else if (load) begin
         on   <= 1'b1;
         xpos <= x_load;
         ypos <= Y_START_C;
      end else if (tick && on) begin
         if (ypos <= Y_MIN_C) begin
            on   <= 1'b0;
            ypos <= Y_START_C;
         end else begin
            ypos <= ypos - 1'b1;
         end
      end
   end
endmodule

// File: rtl/missle_pool_ctl.sv
// Missile pool controller: fire edge detect, cooldown, step divider and
// round-robin slot allocation over N_SLOTS missile slots.
module missle_pool_ctl
   import missle_pkg::*;
#(
   parameter int N_SLOTS  = N_SLOTS_DEF,
   parameter int STEP_DIV = STEP_DIV_DEF,
   parameter int COOLDOWN = COOLDOWN_DEF,
   parameter int Y_START  = Y_START_DEF,
   parameter int Y_MIN    = Y_MIN_DEF
) (
   input logic              pclk,
   input logic              rst,
   missle_pool_ctl_if.slave bus
);
   localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
   localparam int DIV_W = (STEP_DIV > 0) ? $clog2(STEP_DIV + 1) : 1;
   localparam logic [SLOT_IDX_W-1:0] LAST_SLOT = SLOT_IDX_W'(N_SLOTS - 1);

   logic                  btn_prev;
   logic                  fire_req;
   logic                  tick;
   logic                  accept;
   logic                  free_found;
   logic [CD_W-1:0]       cd_cnt;
   logic [DIV_W-1:0]      div_cnt;
   logic [SLOT_IDX_W-1:0] rr_ptr;
   logic [SLOT_IDX_W-1:0] chosen;
   logic [N_SLOTS-1:0]    on_vec;
   logic                  on_arr [N_SLOTS];
   logic [XY_W-1:0]       x_arr  [N_SLOTS];
   logic [XY_W-1:0]       y_arr  [N_SLOTS];

   assign fire_req = bus.missle_button & ~btn_prev;
   assign tick     = (div_cnt == DIV_W'(STEP_DIV));
   assign accept   = fire_req & ~bus.ship_dead & (cd_cnt == '0) & free_found;

   // Lowest free slot at or above rr_ptr wins; otherwise lowest free below it
   always_comb begin
      free_found = 1'b0;
      chosen     = '0;
      for (int i = N_SLOTS - 1; i >= 0; i--) begin
         if (!on_vec[i] && (SLOT_IDX_W'(i) < rr_ptr)) begin
            free_found = 1'b1;
            chosen     = SLOT_IDX_W'(i);
         end
      end
      for (int i = N_SLOTS - 1; i >= 0; i--) begin
         if (!on_vec[i] && (SLOT_IDX_W'(i) >= rr_ptr)) begin
            free_found = 1'b1;
            chosen     = SLOT_IDX_W'(i);
         end
      end
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         btn_prev            <= 1'b0;
         cd_cnt              <= '0;
         div_cnt             <= '0;
         rr_ptr              <= '0;
         bus.launch_out      <= 1'b0;
         bus.launch_slot_out <= '0;
      end else begin
         btn_prev       <= bus.missle_button;
         div_cnt        <= tick ? '0 : div_cnt + 1'b1;
         bus.launch_out <= accept;
         if (accept) begin
            bus.launch_slot_out <= chosen;
            rr_ptr              <= (chosen == LAST_SLOT) ? '0 : chosen + 1'b1;
         end
         if (bus.ship_dead)
            cd_cnt <= '0;
         else if (accept)
            cd_cnt <= CD_W'(COOLDOWN);
         else if (cd_cnt != '0)
            cd_cnt <= cd_cnt - 1'b1;
      end
   end

   for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
      missle_slot #(
         .Y_START (Y_START),
         .Y_MIN   (Y_MIN)
      ) u_slot (
         .pclk   (pclk),
         .rst    (rst),
         .clear  (bus.ship_dead),
         .hit    (bus.hit_in[g]),
         .load   (accept && (chosen == SLOT_IDX_W'(g))),
         .tick   (tick),
         .x_load (bus.xpos_in),
         .xpos   (x_arr[g]),
         .ypos   (y_arr[g]),
         .on     (on_arr[g])
      );
   end

   always_comb begin
      on_vec       = '0;
      bus.xpos_out = '0;
      bus.ypos_out = '0;
      for (int i = 0; i < N_SLOTS; i++) begin
         on_vec[i]                        = on_arr[i];
         bus.xpos_out[XY_W*i +: XY_W]     = x_arr[i];
         bus.ypos_out[XY_W*i +: XY_W]     = y_arr[i];
      end
   end

   assign bus.on_out = on_vec;
endmodule

// File: tb/tb_missle_pool_ctl.sv
// Directed bench: two pool controllers share stimulus; A has a fast step
// tick for flight timing, B a slow one so the pool can fill up.
module tb_missle_pool_ctl;
   import missle_pkg::*;

   localparam int NS = 4;

   logic          pclk;
   logic          rst;
   logic [10:0]   xpos;
   logic          btn;
   logic          dead;
   logic [NS-1:0] hit;
   int            ec;
   int            n_chk;
   int            n_bad;
   int            n_launch;

   missle_pool_ctl_if #(.N_SLOTS(NS)) bus_a ();
   missle_pool_ctl_if #(.N_SLOTS(NS)) bus_b ();

   assign bus_a.xpos_in       = xpos;
   assign bus_a.missle_button = btn;
   assign bus_a.ship_dead     = dead;
   assign bus_a.hit_in        = hit;
   assign bus_b.xpos_in       = xpos;
   assign bus_b.missle_button = btn;
   assign bus_b.ship_dead     = dead;
   assign bus_b.hit_in        = hit;

   missle_pool_ctl #(
      .N_SLOTS(NS), .STEP_DIV(3), .COOLDOWN(10), .Y_START(20), .Y_MIN(16)
   ) dut_a (
      .pclk (pclk),
      .rst  (rst),
      .bus  (bus_a)
   );

   missle_pool_ctl #(
      .N_SLOTS(NS), .STEP_DIV(15), .COOLDOWN(10), .Y_START(20), .Y_MIN(16)
   ) dut_b (
      .pclk (pclk),
      .rst  (rst),
      .bus  (bus_b)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   function automatic logic [10:0] fld(input logic [11*NS-1:0] v, input int i);
      return v[11*i +: 11];
   endfunction

   task automatic step();
      @(posedge pclk);
      #1;
      ec++;
   endtask

   task automatic run_to(input int n);
      while (ec < n) step();
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      btn  = 1'b0;
      dead = 1'b0;
      hit  = '0;
      xpos = '0;
      step();
      step();
      rst = 1'b0;
      ec  = 0;
   endtask

   initial begin
      n_chk = 0;
      n_bad = 0;
      ec    = 0;

      // Reset state on both instances
      do_reset();
      rst = 1'b1;
      step();
      chk("rst_on_a",   32'(bus_a.on_out), 0);
      chk("rst_y3_a",   32'(fld(bus_a.ypos_out, 3)), 20);
      chk("rst_x0_a",   32'(fld(bus_a.xpos_out, 0)), 0);
      chk("rst_lo_a",   32'(bus_a.launch_out), 0);
      chk("rst_ls_a",   32'(bus_a.launch_slot_out), 0);
      chk("rst_on_b",   32'(bus_b.on_out), 0);
      chk("rst_y0_b",   32'(fld(bus_b.ypos_out, 0)), 20);

      // Flight timing and cooldown on instance A
      do_reset();
      btn = 1'b1; xpos = 11'd300;
      step();
      btn = 1'b0;
      chk("a_l1_lo",    32'(bus_a.launch_out), 1);
      chk("a_l1_slot",  32'(bus_a.launch_slot_out), 0);
      chk("a_l1_on",    32'(bus_a.on_out), 4'b0001);
      chk("a_l1_x0",    32'(fld(bus_a.xpos_out, 0)), 300);
      chk("a_l1_y0",    32'(fld(bus_a.ypos_out, 0)), 20);
      step();
      chk("a_lo_pulse", 32'(bus_a.launch_out), 0);
      run_to(3);
      chk("a_y0_e3",    32'(fld(bus_a.ypos_out, 0)), 20);
      run_to(4);
      chk("a_y0_e4",    32'(fld(bus_a.ypos_out, 0)), 19);
      run_to(5);
      btn = 1'b1;
      step();
      btn = 1'b0;
      chk("a_cd_lo",    32'(bus_a.launch_out), 0);
      chk("a_cd_on",    32'(bus_a.on_out), 4'b0001);
      run_to(12);
      btn = 1'b1; xpos = 11'd500;
      step();
      btn = 1'b0;
      chk("a_l2_lo",    32'(bus_a.launch_out), 1);
      chk("a_l2_slot",  32'(bus_a.launch_slot_out), 1);
      chk("a_l2_on",    32'(bus_a.on_out), 4'b0011);
      chk("a_l2_x1",    32'(fld(bus_a.xpos_out, 1)), 500);
      chk("a_l2_y0",    32'(fld(bus_a.ypos_out, 0)), 17);
      run_to(16);
      chk("a_y0_e16",   32'(fld(bus_a.ypos_out, 0)), 16);
      run_to(19);
      chk("a_on_e19",   32'(bus_a.on_out), 4'b0011);
      run_to(20);
      chk("a_ret_on",   32'(bus_a.on_out), 4'b0010);
      chk("a_ret_y0",   32'(fld(bus_a.ypos_out, 0)), 20);
      chk("a_ret_x0",   32'(fld(bus_a.xpos_out, 0)), 300);
      chk("a_y1_e20",   32'(fld(bus_a.ypos_out, 1)), 18);

      // Pool fill, hits, ship death and held button on instance B
      do_reset();
      btn = 1'b1; xpos = 11'd100;
      step();
      btn = 1'b0;
      run_to(11);
      btn = 1'b1; xpos = 11'd110;
      step();
      btn = 1'b0;
      run_to(22);
      btn = 1'b1; xpos = 11'd120;
      step();
      btn = 1'b0;
      run_to(33);
      btn = 1'b1; xpos = 11'd130;
      step();
      btn = 1'b0;
      chk("b_l4_slot",  32'(bus_b.launch_slot_out), 3);
      chk("b_l4_on",    32'(bus_b.on_out), 4'b1111);
      chk("b_l4_y0",    32'(fld(bus_b.ypos_out, 0)), 18);
      chk("b_l4_y2",    32'(fld(bus_b.ypos_out, 2)), 19);
      run_to(44);
      btn = 1'b1; xpos = 11'd135;
      step();
      btn = 1'b0;
      chk("b_full_lo",  32'(bus_b.launch_out), 0);
      chk("b_full_on",  32'(bus_b.on_out), 4'b1111);
      chk("b_full_x0",  32'(fld(bus_b.xpos_out, 0)), 100);
      hit = 4'b0100;
      step();
      hit = '0;
      chk("b_hit2_on",  32'(bus_b.on_out), 4'b1011);
      chk("b_hit2_y2",  32'(fld(bus_b.ypos_out, 2)), 20);
      chk("b_hit2_y1",  32'(fld(bus_b.ypos_out, 1)), 18);
      btn = 1'b1; xpos = 11'd140;
      step();
      btn = 1'b0;
      chk("b_reuse_lo", 32'(bus_b.launch_out), 1);
      chk("b_reuse_sl", 32'(bus_b.launch_slot_out), 2);
      chk("b_reuse_x2", 32'(fld(bus_b.xpos_out, 2)), 140);
      chk("b_reuse_on", 32'(bus_b.on_out), 4'b1111);
      run_to(49);
      hit = 4'b0010;
      step();
      chk("b_hit1_on",  32'(bus_b.on_out), 4'b1101);
      chk("b_hit1_y1",  32'(fld(bus_b.ypos_out, 1)), 20);
      chk("b_hit1_y0",  32'(fld(bus_b.ypos_out, 0)), 17);
      chk("b_hit1_y3",  32'(fld(bus_b.ypos_out, 3)), 19);
      step();
      hit = '0;
      chk("b_hit_off",  32'(bus_b.on_out), 4'b1101);
      dead = 1'b1;
      step();
      chk("b_dead_on",  32'(bus_b.on_out), 4'b0000);
      chk("b_dead_y0",  32'(fld(bus_b.ypos_out, 0)), 20);
      chk("b_dead_x0",  32'(fld(bus_b.xpos_out, 0)), 100);
      btn = 1'b1;
      step();
      btn = 1'b0;
      chk("b_dead_lo",  32'(bus_b.launch_out), 0);
      chk("b_dead_on2", 32'(bus_b.on_out), 4'b0000);
      dead = 1'b0;
      step();
      btn = 1'b1; xpos = 11'd150;
      step();
      btn = 1'b0;
      chk("b_alive_lo", 32'(bus_b.launch_out), 1);
      chk("b_alive_sl", 32'(bus_b.launch_slot_out), 3);
      chk("b_alive_x3", 32'(fld(bus_b.xpos_out, 3)), 150);
      chk("b_alive_on", 32'(bus_b.on_out), 4'b1000);
      run_to(66);
      btn      = 1'b1;
      n_launch = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (bus_b.launch_out) n_launch++;
      end
      btn = 1'b0;
      chk("b_hold_cnt", 32'(n_launch), 1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
